// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin memory port arbiter.
//   arb_state_t : two-state FSM encoding (idle / transaction in flight)
//   rr_mask     : priority mask that keeps only requesters above last_idx
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Upper bound on requester count; sizes the generic mask helper.
    localparam int unsigned ARB_MAX_REQ = 16;

    // Returns ~((2 << last_idx) - 1), limited to num_req bits: every
    // requester strictly above the last one served keeps its priority.
    // For last_idx = num_req-1 the mask is empty, which makes the caller
    // fall back to plain lowest-index priority (the wrap-around case).
    function automatic logic [ARB_MAX_REQ-1:0] rr_mask(
        input logic [3:0]  last_idx,
        input int unsigned num_req
    );
        logic [31:0] upto;
        logic [31:0] in_range;
        upto     = (32'd2 << last_idx) - 32'd1;
        in_range = (32'd1 << num_req) - 32'd1;
        return ARB_MAX_REQ'(~upto & in_range);
    endfunction

endpackage

// File: rtl/Multiplexer_Binary_Behavioural.sv
// ---------------------------------------------------------------------------
// Multiplexer_Binary_Behavioural
// Binary-selected word multiplexer over a packed input bus.
//   selector_i : word index
//   words_i    : INPUT_COUNT words, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   word_o     : selected word (zero if selector is out of range)
// ---------------------------------------------------------------------------
module Multiplexer_Binary_Behavioural #(
    parameter  int WORD_WIDTH  = 32,
    parameter  int INPUT_COUNT = 4,
    localparam int SEL_W       = $clog2(INPUT_COUNT)
) (
    input  logic [SEL_W-1:0]                  selector_i,
    input  logic [WORD_WIDTH*INPUT_COUNT-1:0] words_i,
    output logic [WORD_WIDTH-1:0]             word_o
);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            if (selector_i == SEL_W'(i)) begin
                word_o = words_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/Priority_Encoder.sv
// ---------------------------------------------------------------------------
// Priority_Encoder
// Lowest-index-first priority encoder.
//   word_i  : request vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : at least one bit of word_i is set
// ---------------------------------------------------------------------------
module Priority_Encoder #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (word_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign valid_o = |word_i;

endmodule

// File: rtl/rr_pointer_select.sv
// ---------------------------------------------------------------------------
// rr_pointer_select
// Combinational round-robin pick: first requester above last_idx, else the
// lowest-index requester overall.
//   req_valid_i : per-requester request
//   last_idx_i  : index of the most recently completed grant
//   next_idx_o  : requester to grant next (meaningful when any_req_o)
//   any_req_o   : at least one requester is asking
// ---------------------------------------------------------------------------
module rr_pointer_select
    import arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [IDX_WIDTH-1:0] last_idx_i,
    output logic [IDX_WIDTH-1:0] next_idx_o,
    output logic                 any_req_o
);

    logic [NUM_REQ-1:0]   masked_req;
    logic [IDX_WIDTH-1:0] masked_idx;
    logic [IDX_WIDTH-1:0] unmasked_idx;
    logic                 masked_any;
    logic                 unmasked_any;

    assign masked_req = req_valid_i
                      & NUM_REQ'(rr_mask(4'(last_idx_i), unsigned'(NUM_REQ)));

    Priority_Encoder #(.WIDTH(NUM_REQ)) u_pe_masked (
        .word_i  (masked_req),
        .idx_o   (masked_idx),
        .valid_o (masked_any)
    );

    Priority_Encoder #(.WIDTH(NUM_REQ)) u_pe_unmasked (
        .word_i  (req_valid_i),
        .idx_o   (unmasked_idx),
        .valid_o (unmasked_any)
    );

    // Nobody above the pointer: wrap to the lowest-index requester.
    assign next_idx_o = masked_any ? masked_idx : unmasked_idx;
    assign any_req_o  = unmasked_any;

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_rr_arbiter
// Shares one memory request port between NUM_REQ requesters by round-robin,
// with one transaction in flight; the grant is held until mem_ready.
//   clk, rst           : clock (rising edge), async active-high reset
//   req_valid          : per-requester request
//   req_addr/wdata/wstrb : packed per-requester fields (wstrb==0 -> read)
//   req_ready          : one-hot completion pulse to the granted requester
//   req_rdata          : memory read data, broadcast (valid with req_ready)
//   mem_valid          : request to memory
//   mem_addr/wdata/wstrb : granted requester's fields, zero when idle
//   mem_ready, mem_rdata : memory completion and read data
//   grant_idx          : current / last grant index
// ---------------------------------------------------------------------------
module mem_port_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          mem_valid,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [STRB_WIDTH-1:0]         mem_wstrb,
    input  logic                          mem_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [IDX_WIDTH-1:0]          grant_idx
);

    arb_state_t           state_q,     state_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0] last_idx_q,  last_idx_d;

    logic [IDX_WIDTH-1:0] next_idx;
    logic                 any_req;
    logic                 done;

    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic [STRB_WIDTH-1:0] wstrb_sel;

    rr_pointer_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req_valid_i (req_valid),
        .last_idx_i  (last_idx_q),
        .next_idx_o  (next_idx),
        .any_req_o   (any_req)
    );

    // State and pointer registers. last_idx resets to the top requester so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign done = (state_q == ARB_BUSY) && mem_ready;

    // Next-state logic. A grant is never withdrawn: BUSY only leaves on
    // mem_ready, regardless of what req_valid does meanwhile.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_idx_d = next_idx;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    last_idx_d = grant_idx_q;
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs. req_ready is combinational on mem_ready so completion is
    // reported in the same cycle the memory finishes.
    always_comb begin
        mem_valid = (state_q == ARB_BUSY);
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = done && (grant_idx_q == IDX_WIDTH'(i));
        end
    end

    Multiplexer_Binary_Behavioural #(
        .WORD_WIDTH  (ADDR_WIDTH),
        .INPUT_COUNT (NUM_REQ)
    ) u_mux_addr (
        .selector_i (grant_idx_q),
        .words_i    (req_addr),
        .word_o     (addr_sel)
    );

    Multiplexer_Binary_Behavioural #(
        .WORD_WIDTH  (DATA_WIDTH),
        .INPUT_COUNT (NUM_REQ)
    ) u_mux_wdata (
        .selector_i (grant_idx_q),
        .words_i    (req_wdata),
        .word_o     (wdata_sel)
    );

    Multiplexer_Binary_Behavioural #(
        .WORD_WIDTH  (STRB_WIDTH),
        .INPUT_COUNT (NUM_REQ)
    ) u_mux_wstrb (
        .selector_i (grant_idx_q),
        .words_i    (req_wstrb),
        .word_o     (wstrb_sel)
    );

    // Idle bus is forced to zero so nothing stale leaks to the memory side.
    assign mem_addr  = mem_valid ? addr_sel  : '0;
    assign mem_wdata = mem_valid ? wdata_sel : '0;
    assign mem_wstrb = mem_valid ? wstrb_sel : '0;

    assign req_rdata = mem_rdata;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_rr_arbiter
// Directed bench for the round-robin memory port arbiter (NUM_REQ = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_port_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_wstrb;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    req_rdata;
    logic             mem_valid;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [SW-1:0]    mem_wstrb;
    logic             mem_ready;
    logic [DW-1:0]    mem_rdata;
    logic [1:0]       grant_idx;

    logic [AW-1:0]    exp_addr [NR];
    logic [DW-1:0]    exp_wdata[NR];

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_rr_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Control view {mem_valid, req_ready, grant_idx} against expectation.
    task automatic chk_ctl(input string tag, input logic v, input logic [3:0] rdy, input logic [1:0] g);
        chk(tag, 64'({mem_valid, req_ready, grant_idx}), 64'({v, rdy, g}));
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] g);
        chk_ctl(tag, 1'b0, 4'b0000, g);
        chk({tag, "_bus"}, 64'({mem_addr, mem_wstrb}), 64'd0);
    endtask

    task automatic chk_busy(input string tag, input int g, input logic rdy);
        logic [3:0] oh;
        oh = rdy ? (4'b0001 << g) : 4'b0000;
        chk_ctl(tag, 1'b1, oh, 2'(g));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(exp_addr[g]));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(exp_wdata[g]));
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < NR; i++) begin
            exp_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
            exp_wdata[i] = 32'hA0A0_0000 + 32'(i);
            req_addr[i*AW +: AW]  = exp_addr[i];
            req_wdata[i*DW +: DW] = exp_wdata[i];
            req_wstrb[i*SW +: SW] = 4'hF;
        end

        // Reset state
        step(); #1;
        chk_idle("rst_state", 2'd0);
        step(); rst = 1'b0; #1;

        // 1: idle with no requests
        for (int c = 0; c < 10; c++) begin
            step(); #1;
            chk_ctl("t1_idle", 1'b0, 4'b0000, 2'd0);
        end

        // 2: all requesting, memory always ready -> 0,1,2,3,0 with bubbles
        step(); req_valid = 4'b1111; mem_ready = 1'b1; #1;
        chk_idle("t2_pre", 2'd0);
        for (int k = 0; k < 5; k++) begin
            step(); #1;
            chk_busy("t2_busy", k % 4, 1'b1);
            step();
            if (k == 4) req_valid = 4'b0000;
            #1;
            chk_idle("t2_bubble", 2'(k % 4));
        end

        // 3: single read from requester 2, memory ready on third BUSY cycle
        step();
        req_valid = 4'b0100;
        mem_ready = 1'b0;
        exp_addr[2] = 32'h8000_0010;
        req_addr[2*AW +: AW] = exp_addr[2];
        req_wstrb[2*SW +: SW] = 4'h0;
        #1;
        chk_idle("t3_pre", 2'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            if (c == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            chk_busy("t3_busy", 2, c == 2);
            chk("t3_wstrb", 64'(mem_wstrb), 64'd0);
        end
        chk("t3_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
        step(); req_valid = 4'b0000; mem_ready = 1'b0; #1;
        chk_idle("t3_post", 2'd2);

        // 4: wrap-around - grant 3, then {0,3} requesting -> 0 then 3
        step(); req_valid = 4'b1000; mem_ready = 1'b1; #1;
        chk_idle("t4_pre", 2'd2);
        step(); req_valid = 4'b1001; #1;
        chk_busy("t4_g3a", 3, 1'b1);
        step(); #1;
        chk_idle("t4_bub1", 2'd3);
        step(); #1;
        chk_busy("t4_g0", 0, 1'b1);
        step(); #1;
        chk_idle("t4_bub2", 2'd0);
        step(); #1;
        chk_busy("t4_g3b", 3, 1'b1);
        step(); req_valid = 4'b0000; #1;
        chk_idle("t4_post", 2'd3);

        // 5: reset in the middle of a grant to requester 2
        step(); req_valid = 4'b0100; mem_ready = 1'b0; #1;
        chk_idle("t5_pre", 2'd3);
        step(); #1;
        chk_busy("t5_busy", 2, 1'b0);
        #2 rst = 1'b1; #1;
        chk_idle("t5_async_rst", 2'd0);
        step(); rst = 1'b0; req_valid = 4'b0110; #1;
        chk_idle("t5_released", 2'd0);
        step(); mem_ready = 1'b1; #1;
        chk_busy("t5_g1", 1, 1'b1);
        step(); req_valid = 4'b0000; mem_ready = 1'b0; #1;
        chk_idle("t5_post", 2'd1);

        // 6: stray mem_ready while idle is ignored
        step(); mem_ready = 1'b1; #1;
        chk_idle("t6_stray", 2'd1);
        step(); mem_ready = 1'b0; #1;
        chk_idle("t6_stay", 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
